// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises 10-bit MOSI frames for the RAM
// and serialises 8-bit read data back on MISO.
module spi_slave_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  localparam logic [3:0] FRAME_BITS = 4'd10;
  localparam logic [3:0] TX_BITS    = 4'd8;

  logic [2:0] state_q, state_d;
  logic       rd_addr_received_q, rd_addr_received_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic       tx_busy_q, tx_busy_d;
  logic       tx_done_q, tx_done_d;
  logic       miso_q, miso_d;
  logic [9:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  logic frame_full;
  logic last_bit;

  assign frame_full = (bit_cnt_q == FRAME_BITS);
  assign last_bit   = (bit_cnt_q == FRAME_BITS - 4'd1);

  always_comb begin
    state_d            = state_q;
    rd_addr_received_d = rd_addr_received_q;
    bit_cnt_d          = bit_cnt_q;
    rx_shift_d         = rx_shift_q;
    tx_shift_d         = tx_shift_q;
    tx_cnt_d           = tx_cnt_q;
    tx_busy_d          = tx_busy_q;
    tx_done_d          = tx_done_q;
    miso_d             = miso_q;
    rx_data_d          = rx_data_q;
    rx_valid_d         = 1'b0;

    if (state_q != IDLE && SS_n) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (!SS_n) begin
            state_d   = CHK_CMD;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
          end
        end
        CHK_CMD: begin
          rx_shift_d = {rx_shift_q[8:0], MOSI};
          bit_cnt_d  = 4'd1;
          if (!MOSI)
            state_d = WRITE;
          else if (rd_addr_received_q)
            state_d = READ_DATA;
          else
            state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_full) begin
            rx_shift_d = {rx_shift_q[8:0], MOSI};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (last_bit) begin
              rx_data_d  = {rx_shift_q[8:0], MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)
                rd_addr_received_d = 1'b1;
              if (state_q == READ_DATA)
                rd_addr_received_d = 1'b0;
            end
          end
          // Response phase only opens once the frame has been handed over
          if (state_q == READ_DATA && frame_full) begin
            if (tx_busy_q) begin
              if (tx_cnt_q == TX_BITS) begin
                miso_d    = 1'b0;
                tx_busy_d = 1'b0;
                tx_done_d = 1'b1;
              end else begin
                miso_d     = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
                tx_cnt_d   = tx_cnt_q + 4'd1;
              end
            end else if (tx_valid && !tx_done_q) begin
              miso_d     = tx_data[7];
              tx_shift_d = {tx_data[6:0], 1'b0};
              tx_busy_d  = 1'b1;
              tx_cnt_d   = 4'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      rd_addr_received_q <= 1'b0;
      bit_cnt_q          <= '0;
      rx_shift_q         <= '0;
      tx_shift_q         <= '0;
      tx_cnt_q           <= '0;
      tx_busy_q          <= 1'b0;
      tx_done_q          <= 1'b0;
      miso_q             <= 1'b0;
      rx_data_q          <= '0;
      rx_valid_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      rd_addr_received_q <= rd_addr_received_d;
      bit_cnt_q          <= bit_cnt_d;
      rx_shift_q         <= rx_shift_d;
      tx_shift_q         <= tx_shift_d;
      tx_cnt_q           <= tx_cnt_d;
      tx_busy_q          <= tx_busy_d;
      tx_done_q          <= tx_done_d;
      miso_q             <= miso_d;
      rx_data_q          <= rx_data_d;
      rx_valid_q         <= rx_valid_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave_fsm.md
# spi_slave_fsm

Serial front end of the SPI-slave/RAM subsystem. Deserialises 10-bit MOSI frames into parallel words for the single-port RAM (`rx_data`/`rx_valid`). For read-data frames it captures the RAM's 8-bit response (`tx_data`/`tx_valid`) and serialises it back on MISO. Sits directly upstream of the RAM and is the only block that sees the SPI pins.

## Interface
- Parameters: none. Frame length is fixed at 10 bits and read-data length at 8 bits.
- `clk` input 1: system clock. All sampling and driving happens on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `SS_n` input 1: slave select, active-low. Low frames a transaction.
- `MOSI` input 1: serial data in, MSB first, one bit per `clk`.
- `MISO` output 1: serial data out, registered.
- `rx_data` output 10: assembled frame to RAM. `[9:8]` is the command, `[7:0]` is the payload.
- `rx_valid` output 1: single-cycle strobe qualifying `rx_data`.
- `tx_data` input 8: read data from RAM.
- `tx_valid` input 1: qualifies `tx_data`.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal registers:
  - `rd_addr_received` flag, 1 bit.
  - 4-bit bit counter.
  - 10-bit rx shift register.
  - 8-bit tx shift register.
  - 4-bit tx counter.
  - `tx_busy` flag and `tx_done` flag.
- IDLE: while SS_n=1 stay in IDLE. The first edge that samples SS_n=0 moves to CHK_CMD and clears the counters. MOSI is not captured on this edge.
- CHK_CMD: the MOSI sampled here is frame bit 9. It is shifted in and the bit counter becomes 1.
  - MOSI=0 → WRITE.
  - MOSI=1 and flag=0 → READ_ADD.
  - MOSI=1 and flag=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in MOSI each edge until 10 bits are held.
  - On the edge sampling the 10th bit: `rx_data <= {shift[8:0], MOSI}` and `rx_valid <= 1`.
  - `rx_valid` is cleared on the next edge.
  - The frame is forwarded verbatim. Bit 8 is not checked.
  - MOSI after the 10th bit is ignored.
- Flag updates:
  - The `rx_valid` edge of a READ_ADD frame sets `rd_addr_received`.
  - The `rx_valid` edge of a READ_DATA frame clears it.
- READ_DATA response, after `rx_valid` has been issued:
  - Wait, for any number of cycles, for an edge sampling `tx_valid=1` while not yet busy.
  - On that edge: `MISO <= tx_data[7]`, tx shift register `<= tx_data<<1`, `tx_busy <= 1`, tx counter `<= 1`.
  - On each following edge: MISO takes the next bit MSB-first until 8 bits have been driven.
  - On the edge after the 8th bit: `MISO <= 0`, `tx_busy <= 0`, `tx_done <= 1`. No further capture in this frame.
- `tx_valid` sampled in any other state, or after `tx_done`, is ignored.
- Frame end: the first edge sampling SS_n=1 in any non-IDLE state:
  - moves to IDLE;
  - sets MISO 0 and `rx_valid` 0;
  - clears the counters, `tx_busy` and `tx_done`.
- Abort: an abort before the 10th bit discards the partial frame. No `rx_valid` is issued and the flag is unchanged.
- MISO is 0 whenever the block is not actively serialising.

## Timing
- Edge numbering: E0 is the first edge sampling SS_n=0. Frame bit 9 is sampled at E1, bit 0 at E10.
- `rx_valid` is high between E10 and E11, for exactly one cycle.
- With a RAM that registers `tx_valid` at E11:
  - capture happens at E12;
  - MISO carries `tx_data[7..0]` in the cycles following E12..E19;
  - MISO returns to 0 after E20.
- The master must hold SS_n low through E20 for a complete read.
- A new frame may start on the edge after the SS_n=1 edge. At minimum one IDLE cycle separates frames.
- Reset (asserted at any time, including mid-frame or mid-serialisation):
  - state IDLE;
  - MISO 0, `rx_data` 0, `rx_valid` 0;
  - `rd_addr_received` 0;
  - all counters and shift registers 0.
- After reset is released, the first frame begins only on an edge sampling SS_n=0.

## Test plan
- Write address, MOSI 00_1010_0101: `rx_data`=0x0A5 with `rx_valid` high for one cycle after E10. MISO stays 0 and the flag stays 0.
- Write data, MOSI 01_0011_1100: `rx_data`=0x13C with a single `rx_valid` pulse.
- Read address then read data:
  - Frame 1, MOSI 10_1010_0101: `rx_data`=0x2A5, flag set.
  - Frame 2, MOSI 11_0000_0000, with the RAM model returning 0x3C: MISO=0,0,1,1,1,1,0,0 after E12..E19, and the flag is cleared.
- Read-data frame with flag=0, MOSI 11_xxxx_xxxx: FSM takes READ_ADD. `rx_data` is forwarded with `[9:8]`=11, there is no MISO activity, and the flag becomes 1.
- Abort: SS_n rises after 5 bits. No `rx_valid`, next state IDLE. The next full frame is captured correctly.
- Reset mid-serialisation: assert `rst_n`=0 while MISO is shifting. MISO is 0 immediately (asynchronously), the flag is 0, and the next frame behaves as from power-on.
